count_seq_checker: RTL and testbench

In-design sequence checker for free-running up-counters: it samples a WIDTH-bit count value each valid cycle and checks that every sample equals the previous sample plus one, modulo 2^WIDTH. It sits next to the 4-bit up-counter at the consumer end of that counter's output. It provides lock status, a one-cycle error pulse, and saturating error and wrap statistics that can be read through its outputs.

---
 rtl/count_seq_checker.sv | 112 +++++++++++
 tb/tb_count_seq_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running up-counter: verifies each valid sample is the
// previous sample plus one (mod 2^WIDTH), reports lock status, error pulses and statistics.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int STAT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cnt_valid,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count
);

    localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     good_cnt_q, good_cnt_d;
    logic [WIDTH-1:0]  expected_d;
    logic              err_pulse_d;
    logic [STAT_W-1:0] err_count_d, wrap_count_d;
    logic              match;

    // The reference sample is never stored directly; expected (ref + 1) carries the same
    // information and lets every output be a flop that resets to zero.
    assign match = (cnt_in == expected);

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        expected_d   = expected;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count;
        wrap_count_d = wrap_count;

        if (cnt_valid) begin
            expected_d = cnt_in + WIDTH'(1);
            case (state_q)
                UNSYNC: begin
                    good_cnt_d = '0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_d == GW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if ((cnt_in == '0) && (wrap_count != '1)) begin
                            wrap_count_d = wrap_count + STAT_W'(1);
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        good_cnt_d  = '0;
                        state_d     = ACQUIRE;
                        if (err_count != '1) begin
                            err_count_d = err_count + STAT_W'(1);
                        end
                    end
                end
                default: begin
                    good_cnt_d = '0;
                    state_d    = UNSYNC;
                end
            endcase
        end

        // Clear only touches the statistics and overrides a same-cycle increment.
        if (clear) begin
            err_count_d  = '0;
            wrap_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNSYNC;
            good_cnt_q <= '0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            expected   <= expected_d;
            locked     <= (state_d == LOCKED);
            err_pulse  <= err_pulse_d;
            err_count  <= err_count_d;
            wrap_count <= wrap_count_d;
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker: directed scenarios followed by random
// sample streams, all compared against a sample-history reference model.
module tb_count_seq_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int STAT_W   = 2;
    localparam int MOD      = 1 << WIDTH;
    localparam int SMAX     = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cnt_valid;
    logic [WIDTH-1:0]  cnt_in;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic [WIDTH-1:0]  expected;
    logic [STAT_W-1:0] err_count;
    logic [STAT_W-1:0] wrap_count;

    int total  = 0;
    int passed = 0;

    // Reference model: history of accepted samples summarised as plain integers.
    bit have_prev;
    int prev_sample;
    int streak;
    bit m_locked;
    bit m_err;
    int m_errs;
    int m_wraps;
    int stim_val;

    count_seq_checker #(
        .WIDTH   (WIDTH),
        .LOCK_CNT(LOCK_CNT),
        .STAT_W  (STAT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_valid (cnt_valid),
        .cnt_in    (cnt_in),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .expected  (expected),
        .err_count (err_count),
        .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    function automatic int model_expected();
        return have_prev ? (prev_sample + 1) % MOD : 0;
    endfunction

    task automatic modelReset();
        have_prev   = 1'b0;
        prev_sample = 0;
        streak      = 0;
        m_locked    = 1'b0;
        m_err       = 1'b0;
        m_errs      = 0;
        m_wraps     = 0;
    endtask

    task automatic modelAccept(input bit v, input int val, input bit clr);
        bit in_order;
        m_err = 1'b0;
        if (v) begin
            in_order = have_prev && (val == (prev_sample + 1) % MOD);
            if (!have_prev) begin
                streak   = 0;
                m_locked = 1'b0;
            end else if (m_locked) begin
                if (in_order) begin
                    if (val == 0) m_wraps = (m_wraps < SMAX) ? m_wraps + 1 : SMAX;
                end else begin
                    m_err    = 1'b1;
                    m_errs   = (m_errs < SMAX) ? m_errs + 1 : SMAX;
                    m_locked = 1'b0;
                    streak   = 0;
                end
            end else begin
                streak   = in_order ? streak + 1 : 0;
                m_locked = (streak >= LOCK_CNT);
            end
            have_prev   = 1'b1;
            prev_sample = val;
        end
        if (clr) begin
            m_errs  = 0;
            m_wraps = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".locked"},     32'(locked),     32'(m_locked));
        checkOutput({phase, ".err_pulse"},  32'(err_pulse),  32'(m_err));
        checkOutput({phase, ".expected"},   32'(expected),   32'(model_expected()));
        checkOutput({phase, ".err_count"},  32'(err_count),  32'(m_errs));
        checkOutput({phase, ".wrap_count"}, 32'(wrap_count), 32'(m_wraps));
    endtask

    // Drives one cycle of input away from the active edge, then checks just after it.
    task automatic applyStimulus(input string phase, input bit v, input int val, input bit clr);
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = WIDTH'(val);
        clear     = clr;
        @(posedge clk);
        #1;
        modelAccept(v, val, clr);
        checkAll(phase);
    endtask

    task automatic forceMismatch(input string phase, input bit clr);
        applyStimulus(phase, 1'b1, (model_expected() + 5) % MOD, clr);
    endtask

    task automatic relock(input string phase);
        for (int i = 0; i < LOCK_CNT; i++) applyStimulus(phase, 1'b1, model_expected(), 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cnt_valid = 1'b0;
        cnt_in    = '0;
        clear     = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 5; v <= 8; v++) applyStimulus("lock", 1'b1, v, 1'b0);
        checkOutput("lock.locked_after_3rd", 32'(locked), 32'd1);

        for (int v = 9; v <= 17; v++) applyStimulus("wrap", 1'b1, v % MOD, 1'b0);
        checkOutput("wrap.count_one", 32'(wrap_count), 32'd1);

        for (int v = 2; v <= 5; v++) applyStimulus("locked_run", 1'b1, v, 1'b0);
        applyStimulus("resync_err", 1'b1, 9, 1'b0);
        checkOutput("resync.err_pulse", 32'(err_pulse), 32'd1);
        applyStimulus("resync", 1'b1, 10, 1'b0);
        applyStimulus("resync", 1'b1, 11, 1'b0);
        checkOutput("resync.relocked", 32'(locked), 32'd1);

        applyStimulus("gap", 1'b1, 12, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("gap_idle", 1'b0, $urandom_range(0, MOD - 1), 1'b0);
        applyStimulus("gap", 1'b1, 13, 1'b0);

        applyStimulus("acq_enter", 1'b1, 2, 1'b0);
        applyStimulus("acq_mismatch", 1'b1, 7, 1'b0);
        checkOutput("acq_mismatch.expected", 32'(expected), 32'd8);
        relock("acq_relock");

        for (int i = 0; i < 3; i++) begin
            forceMismatch("saturate", 1'b0);
            relock("saturate_relock");
        end
        checkOutput("saturate.err_count", 32'(err_count), 32'(SMAX));

        forceMismatch("clear_mismatch", 1'b1);
        checkOutput("clear_mismatch.pulse", 32'(err_pulse), 32'd1);
        relock("clear_relock");
        applyStimulus("clear_idle", 1'b0, 0, 1'b1);

        forceMismatch("pre_reset", 1'b0);
        relock("pre_reset");
        forceMismatch("pre_reset", 1'b0);
        relock("pre_reset");
        applyStimulus("pre_reset_idle", 1'b0, 0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 6; v <= 8; v++) applyStimulus("post_reset", 1'b1, v, 1'b0);

        stim_val = 8;
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit clr;
            int val;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            val = ($urandom_range(0, 6) != 0) ? (stim_val + 1) % MOD : $urandom_range(0, MOD - 1);
            if (v) stim_val = val;
            applyStimulus("random", v, val, clr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
